pattern_sequencer: RTL and testbench

//  Frame-synchronous controller for the HDMI test-pattern generator. It selects the pattern

---
 rtl/pattern_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pattern_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Frame-synchronous mode / single-colour selector for the HDMI test-pattern generator.
// Optional build macro DEBOUNCE_EN adds a DB_CYCLES-long stability filter on the button.
//
// state   | meaning
// S_RUN   | normal operation, counting dwell frames while I_auto=1
// S_WAIT  | manual request latched, waiting for the next frame tick
// S_APPLY | one cycle: advance mode (and palette on wrap), clear dwell
module pattern_sequencer #(
  parameter int FRAMES_PER_MODE = 120,
  parameter int NUM_MODES       = 4,
  parameter bit VS_POL          = 1'b0,
  parameter int DB_CYCLES       = 250000
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic       I_vs,
  input  logic       I_auto,
  input  logic       I_btn_n,
  output logic [2:0] O_mode,
  output logic [7:0] O_single_r,
  output logic [7:0] O_single_g,
  output logic [7:0] O_single_b,
  output logic       O_frame_tick,
  output logic       O_pending
);

  localparam int DW = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(FRAMES_PER_MODE - 1);
  localparam logic [2:0]    MODE_LAST  = 3'(NUM_MODES - 1);

  if (NUM_MODES < 1 || NUM_MODES > 8 || FRAMES_PER_MODE < 1 || DB_CYCLES < 1) begin : g_param_check
    $error("pattern_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_APPLY} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic            advance;
  logic            vs_s1, vs_s2, vs_act, vs_act_q;
  logic            btn_s1, btn_s2, btn_db, btn_db_q;
  logic            press;
  logic [2:0]      pal_idx;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 24'hFF0000;
      3'd1:    palette = 24'h00FF00;
      3'd2:    palette = 24'h0000FF;
      3'd3:    palette = 24'hFFFFFF;
      3'd4:    palette = 24'hFFFF00;
      3'd5:    palette = 24'h00FFFF;
      3'd6:    palette = 24'hFF00FF;
      default: palette = 24'h000000;
    endcase
  endfunction

  // Synchronizers reset to the inactive levels so reset never produces a tick or press.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_s1        <= ~VS_POL;
      vs_s2        <= ~VS_POL;
      vs_act_q     <= 1'b0;
      O_frame_tick <= 1'b0;
      btn_s1       <= 1'b1;
      btn_s2       <= 1'b1;
      btn_db_q     <= 1'b1;
    end else begin
      vs_s1        <= I_vs;
      vs_s2        <= vs_s1;
      vs_act_q     <= vs_act;
      O_frame_tick <= vs_act & ~vs_act_q;
      btn_s1       <= I_btn_n;
      btn_s2       <= btn_s1;
      btn_db_q     <= btn_db;
    end
  end

  assign vs_act = vs_s2 ~^ VS_POL;
  assign press  = btn_db_q & ~btn_db;

`ifdef DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LOAD = DBW'(DB_CYCLES - 1);
  logic [DBW-1:0] db_cnt;

  // Down-counter reloads whenever the input matches the filtered level or bounces back.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      btn_db <= 1'b1;
      db_cnt <= DB_LOAD;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= DB_LOAD;
    end else if (db_cnt == '0) begin
      btn_db <= btn_s2;
      db_cnt <= DB_LOAD;
    end else begin
      db_cnt <= db_cnt - 1'b1;
    end
  end
`else
  assign btn_db = btn_s2;
`endif

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= S_RUN;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    advance   = 1'b0;
    case (state)
      S_RUN: begin
        if (press) begin
          state_nxt = S_WAIT;
        end else if (O_frame_tick && I_auto) begin
          if (dwell == DWELL_LAST) state_nxt = S_APPLY;
          else                     dwell_nxt = dwell + 1'b1;
        end
      end
      S_WAIT: begin
        if (O_frame_tick) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        state_nxt = S_RUN;
        dwell_nxt = '0;
        advance   = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
    if (!I_auto) dwell_nxt = '0;
  end

  assign O_pending = (state == S_WAIT);

  // Colour is loaded from the next palette entry on the same edge as the mode wrap.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_mode                               <= 3'd0;
      pal_idx                              <= 3'd0;
      {O_single_r, O_single_g, O_single_b} <= palette(3'd0);
    end else if (advance) begin
      if (O_mode == MODE_LAST) begin
        O_mode                               <= 3'd0;
        pal_idx                              <= pal_idx + 3'd1;
        {O_single_r, O_single_g, O_single_b} <= palette(pal_idx + 3'd1);
      end else begin
        O_mode <= O_mode + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer (FRAMES_PER_MODE=2, NUM_MODES=4).
// Expectations adapt to the DEBOUNCE_EN build (DB_CYCLES=16).
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic       auto_en = 1'b0;
  logic       btn_n = 1'b1;
  logic [2:0] mode;
  logic [7:0] single_r, single_g, single_b;
  logic       frame_tick, pending;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DEBOUNCE_EN
  localparam int BTN_LAT   = 18;
  localparam int PRESS_LEN = 24;
`else
  localparam int BTN_LAT   = 2;
  localparam int PRESS_LEN = 3;
`endif
  localparam int BTN_AT = (BTN_LAT < 3) ? 3 - BTN_LAT : 0;
  localparam int VS_AT  = BTN_AT + BTN_LAT - 3;

  pattern_sequencer #(
    .FRAMES_PER_MODE(2),
    .NUM_MODES      (4),
    .VS_POL         (1'b0),
    .DB_CYCLES      (16)
  ) dut (
    .I_pxl_clk   (clk),
    .I_rst_n     (rst_n),
    .I_vs        (vs),
    .I_auto      (auto_en),
    .I_btn_n     (btn_n),
    .O_mode      (mode),
    .O_single_r  (single_r),
    .O_single_g  (single_g),
    .O_single_b  (single_b),
    .O_frame_tick(frame_tick),
    .O_pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    vs = 1'b0;
    clks(4);
    vs = 1'b1;
    clks(8);
  endtask

  task automatic press_btn(input int len);
    btn_n = 1'b0;
    clks(len);
    btn_n = 1'b1;
    clks(len);
  endtask

  function automatic logic [23:0] single();
    return {single_r, single_g, single_b};
  endfunction

  initial begin
    int exp_mode[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    // reset with VS toggling
    clks(1);
    for (int i = 0; i < 6; i++) begin
      vs = ~vs;
      clks(1);
    end
    vs = 1'b1;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_single", 32'(single()), 32'hFF0000);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    clks(4);
    check("post_rst_tick", 32'(frame_tick), 32'd0);

    // auto advance every 2 frames
    auto_en = 1'b1;
    check("auto_mode_0", 32'(mode), 32'(exp_mode[0]));
    for (int k = 1; k < 9; k++) begin
      frame();
      check($sformatf("auto_mode_%0d", k), 32'(mode), 32'(exp_mode[k]));
    end
    check("auto_wrap_single", 32'(single()), 32'h00FF00);
    auto_en = 1'b0;
    clks(2);

    // manual press, apply at next frame with exact latency
    btn_n = 1'b0;
    clks(BTN_LAT + 1);
    check("man_pending", 32'(pending), 32'd1);
    btn_n = 1'b1;
    clks(BTN_LAT + 4);
    check("man_mode_held", 32'(mode), 32'd0);
    vs = 1'b0;
    clks(2);
    check("man_tick_p2", 32'(frame_tick), 32'd0);
    clks(1);
    check("man_tick_p3", 32'(frame_tick), 32'd1);
    check("man_mode_p3", 32'(mode), 32'd0);
    clks(1);
    check("man_tick_p4", 32'(frame_tick), 32'd0);
    check("man_mode_p4", 32'(mode), 32'd0);
    clks(1);
    check("man_mode_p5", 32'(mode), 32'd1);
    check("man_pending_p5", 32'(pending), 32'd0);
    vs = 1'b1;
    clks(8);

    // three presses in one frame give one advance
    for (int i = 0; i < 3; i++) press_btn(PRESS_LEN);
    check("multi_pending", 32'(pending), 32'd1);
    frame();
    check("multi_mode", 32'(mode), 32'd2);
    check("multi_pending_clr", 32'(pending), 32'd0);

    // press in the same cycle as the tick waits for the following frame
    for (int c = 0; c <= VS_AT + 3; c++) begin
      if (c == VS_AT) vs = 1'b0;
      if (c == BTN_AT) btn_n = 1'b0;
      clks(1);
    end
    check("coinc_pending", 32'(pending), 32'd1);
    check("coinc_mode_p4", 32'(mode), 32'd2);
    clks(2);
    check("coinc_mode_p6", 32'(mode), 32'd2);
    vs = 1'b1;
    btn_n = 1'b1;
    clks(8 + BTN_LAT);
    check("coinc_still_pending", 32'(pending), 32'd1);
    frame();
    check("coinc_mode_next", 32'(mode), 32'd3);

    // 10-clock glitch: filtered only in the debounce build
    btn_n = 1'b0;
    clks(10);
    btn_n = 1'b1;
    clks(30);
`ifdef DEBOUNCE_EN
    check("glitch_filtered", 32'(pending), 32'd0);
    btn_n = 1'b0;
    clks(20);
    check("long_press_pending", 32'(pending), 32'd1);
    btn_n = 1'b1;
    clks(30);
`else
    check("glitch_pending", 32'(pending), 32'd1);
`endif
    frame();
    check("wrap2_mode", 32'(mode), 32'd0);
    check("wrap2_single", 32'(single()), 32'h0000FF);

    // reset drops a pending request
    btn_n = 1'b0;
    clks(BTN_LAT + 1);
    check("rst2_pending_before", 32'(pending), 32'd1);
    rst_n = 1'b0;
    btn_n = 1'b1;
    clks(2);
    check("rst2_pending", 32'(pending), 32'd0);
    check("rst2_single", 32'(single()), 32'hFF0000);
    rst_n = 1'b1;
    clks(3);
    frame();
    check("rst2_mode_after_frame", 32'(mode), 32'd0);
    check("rst2_pending_after_frame", 32'(pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
